// File: rtl/y86_pkg.sv
// Shared Y-86 encodings: instruction/function codes, one-hot stat values and
// the condition-code record used by the execute stage.
package y86_pkg;

  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0100;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0001;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  function automatic logic cond_eval(input logic [3:0] ifun, input cc_t flags);
    logic lt;
    lt = flags.sf ^ flags.of;
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | flags.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = flags.zf;
      C_NE:    cond_eval = ~flags.zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~flags.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// E pipeline register fields into the execute stage and the M pipeline
// register fields it drives toward data_memory.
interface execute_stage_if #(parameter int DATA_W = 64);

  logic [3:0]        E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [DATA_W-1:0] E_valC;
  logic [DATA_W-1:0] E_valA;
  logic [DATA_W-1:0] E_valB;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;

  logic [3:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_destE;
  logic [3:0]        M_destM;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM
  );

endinterface

// File: rtl/y86_alu.sv
// Combinational Y-86 ALU: computes aluB OP aluA and the {ZF,SF,OF} flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_fun,
  output logic [DATA_W-1:0] alu_result,
  output cc_t               alu_flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] res;
  logic              ovf;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (alu_fun)
      ALU_ADD: begin
        res = alu_b + alu_a;
        ovf = (alu_a[MSB] == alu_b[MSB]) && (res[MSB] != alu_a[MSB]);
      end
      ALU_SUB: begin
        res = alu_b - alu_a;
        ovf = (alu_a[MSB] != alu_b[MSB]) && (res[MSB] != alu_b[MSB]);
      end
      ALU_AND: res = alu_b & alu_a;
      ALU_XOR: res = alu_b ^ alu_a;
      default: res = '0;
    endcase
    alu_result   = res;
    alu_flags.zf = (res == '0);
    alu_flags.sf = res[MSB];
    alu_flags.of = ovf;
  end

endmodule

// File: rtl/execute_stage.sv
// Y-86 execute stage: operand selection, ALU, condition evaluation, the
// condition-code register and the M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  execute_stage_if.slave    e_if,
  input  logic [3:0]        m_stat,
  input  logic [3:0]        W_stat,
  input  logic              M_bubble,
  output logic [DATA_W-1:0] e_valE,
  output logic              e_Cnd,
  output logic [3:0]        e_dstE,
  output logic [2:0]        cc
);

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alu_fun;
  logic [DATA_W-1:0] alu_result;
  cc_t               alu_flags;
  logic              op_invalid;

  cc_t               cc_d, cc_q;
  logic [3:0]        mstat_d, mstat_q;
  logic [3:0]        micode_d, micode_q;
  logic              mcnd_d, mcnd_q;
  logic [DATA_W-1:0] mvale_d, mvale_q;
  logic [DATA_W-1:0] mvala_d, mvala_q;
  logic [3:0]        mdeste_d, mdeste_q;
  logic [3:0]        mdestm_d, mdestm_q;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_if.E_icode)
      RRMOVQ, OPQ:            alu_a = e_if.E_valA;
      IRMOVQ, RMMOVQ, MRMOVQ: alu_a = e_if.E_valC;
      CALL, PUSHQ:            alu_a = '0 - DATA_W'(8);
      RET, POPQ:              alu_a = DATA_W'(8);
      default:                alu_a = '0;
    endcase
    case (e_if.E_icode)
      RMMOVQ, MRMOVQ, OPQ, CALL, RET, PUSHQ, POPQ: alu_b = e_if.E_valB;
      default:                                     alu_b = '0;
    endcase
    alu_fun    = (e_if.E_icode == OPQ) ? e_if.E_ifun : ALU_ADD;
    op_invalid = (e_if.E_icode == OPQ) && (e_if.E_ifun > ALU_XOR);
  end

  y86_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_fun    (alu_fun),
    .alu_result (alu_result),
    .alu_flags  (alu_flags)
  );

  // Conditions read the committed cc, never the flags produced this cycle.
  always_comb begin
    e_valE = alu_result;
    e_Cnd  = 1'b0;
    if (e_if.E_icode == RRMOVQ || e_if.E_icode == JXX) begin
      e_Cnd = cond_eval(e_if.E_ifun, cc_q);
    end
    e_dstE = (e_if.E_icode == RRMOVQ && !e_Cnd) ? REG_NONE : e_if.E_dstE;
  end

  always_comb begin
    cc_d = cc_q;
    if (!M_bubble && e_if.E_icode == OPQ && e_if.E_stat == STAT_AOK &&
        m_stat == STAT_AOK && W_stat == STAT_AOK) begin
      cc_d = alu_flags;
    end

    mstat_d  = STAT_AOK;
    micode_d = NOP;
    mcnd_d   = 1'b0;
    mvale_d  = '0;
    mvala_d  = '0;
    mdeste_d = REG_NONE;
    mdestm_d = REG_NONE;
    if (!M_bubble) begin
      mstat_d  = (op_invalid && e_if.E_stat == STAT_AOK) ? STAT_INS : e_if.E_stat;
      micode_d = e_if.E_icode;
      mcnd_d   = e_Cnd;
      mvale_d  = alu_result;
      mvala_d  = e_if.E_valA;
      mdeste_d = e_dstE;
      mdestm_d = e_if.E_dstM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q     <= CC_RESET;
      mstat_q  <= STAT_AOK;
      micode_q <= NOP;
      mcnd_q   <= 1'b0;
      mvale_q  <= '0;
      mvala_q  <= '0;
      mdeste_q <= REG_NONE;
      mdestm_q <= REG_NONE;
    end else begin
      cc_q     <= cc_d;
      mstat_q  <= mstat_d;
      micode_q <= micode_d;
      mcnd_q   <= mcnd_d;
      mvale_q  <= mvale_d;
      mvala_q  <= mvala_d;
      mdeste_q <= mdeste_d;
      mdestm_q <= mdestm_d;
    end
  end

  assign cc           = cc_q;
  assign e_if.M_stat  = mstat_q;
  assign e_if.M_icode = micode_q;
  assign e_if.M_Cnd   = mcnd_q;
  assign e_if.M_valE  = mvale_q;
  assign e_if.M_valA  = mvala_q;
  assign e_if.M_destE = mdeste_q;
  assign e_if.M_destM = mdestm_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed Y-86 vectors, a reference model checked
// every cycle, and literal expectations for the headline cases.
module tb_execute_stage;
  import y86_pkg::*;

  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic [3:0]    m_stat;
  logic [3:0]    W_stat;
  logic          M_bubble;
  logic [DW-1:0] e_valE;
  logic          e_Cnd;
  logic [3:0]    e_dstE;
  logic [2:0]    cc;

  execute_stage_if #(.DATA_W(DW)) eif ();

  execute_stage #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .e_if     (eif.slave),
    .m_stat   (m_stat),
    .W_stat   (W_stat),
    .M_bubble (M_bubble),
    .e_valE   (e_valE),
    .e_Cnd    (e_Cnd),
    .e_dstE   (e_dstE),
    .cc       (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] val_e;
    logic        cnd;
    logic [3:0]  dst_e;
    logic [2:0]  flags;
    logic        ins;
  } comb_t;

  // Reference arithmetic: wide signed sums, overflow means "does not fit in 64 signed bits".
  function automatic comb_t model_comb(input logic [3:0] ic, input logic [3:0] fn,
                                       input logic [63:0] va, input logic [63:0] vb,
                                       input logic [63:0] vc, input logic [3:0] de,
                                       input logic [2:0] ccv);
    comb_t r;
    logic [63:0] opa, opb, res;
    logic signed [65:0] sa, sb, full;
    logic of, zf, sf, lt;
    r = '0;
    opa = 64'd0;
    opb = 64'd0;
    if (ic == 4'h2 || ic == 4'h6) opa = va;
    else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) opa = vc;
    else if (ic == 4'h8 || ic == 4'hA) opa = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (ic == 4'h9 || ic == 4'hB) opa = 64'd8;
    if (ic inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) opb = vb;
    sa = $signed({{2{opa[63]}}, opa});
    sb = $signed({{2{opb[63]}}, opb});
    full = 66'sd0;
    of = 1'b0;
    res = 64'd0;
    if (ic != 4'h6 || fn == 4'h0) begin
      full = sb + sa;
      res = full[63:0];
      of = (full[65:63] != 3'b000) && (full[65:63] != 3'b111);
    end else if (fn == 4'h1) begin
      full = sb - sa;
      res = full[63:0];
      of = (full[65:63] != 3'b000) && (full[65:63] != 3'b111);
    end else if (fn == 4'h2) res = opa & opb;
    else if (fn == 4'h3) res = opa ^ opb;
    else r.ins = 1'b1;
    r.val_e = res;
    r.flags = {res == 64'd0, res[63], of};
    zf = ccv[2];
    sf = ccv[1];
    lt = sf ^ ccv[0];
    if (ic == 4'h2 || ic == 4'h7) begin
      case (fn)
        4'd0: r.cnd = 1'b1;
        4'd1: r.cnd = lt || zf;
        4'd2: r.cnd = lt;
        4'd3: r.cnd = zf;
        4'd4: r.cnd = !zf;
        4'd5: r.cnd = !lt;
        4'd6: r.cnd = !lt && !zf;
        default: r.cnd = 1'b0;
      endcase
    end
    r.dst_e = (ic == 4'h2 && !r.cnd) ? 4'hF : de;
    return r;
  endfunction

  comb_t       mc;
  logic [3:0]  x_stat, x_icode, x_deste, x_destm;
  logic        x_cnd;
  logic [63:0] x_vale, x_vala;
  logic [2:0]  x_cc;

  always_comb mc = model_comb(eif.E_icode, eif.E_ifun, eif.E_valA, eif.E_valB,
                              eif.E_valC, eif.E_dstE, x_cc);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      x_stat  <= 4'b1000;
      x_icode <= 4'h1;
      x_cnd   <= 1'b0;
      x_vale  <= 64'd0;
      x_vala  <= 64'd0;
      x_deste <= 4'hF;
      x_destm <= 4'hF;
      if (!rst_n) x_cc <= 3'b100;
    end else begin
      x_stat  <= (mc.ins && eif.E_stat == 4'b1000) ? 4'b0001 : eif.E_stat;
      x_icode <= eif.E_icode;
      x_cnd   <= mc.cnd;
      x_vale  <= mc.val_e;
      x_vala  <= eif.E_valA;
      x_deste <= mc.dst_e;
      x_destm <= eif.E_dstM;
      if (eif.E_icode == 4'h6 && eif.E_stat == 4'b1000 && m_stat == 4'b1000 &&
          W_stat == 4'b1000) x_cc <= mc.flags;
    end
  end

  int cmp_tests = 0;
  int cmp_fail  = 0;
  int lit_tests = 0;
  int lit_fail  = 0;
  logic cmp_en = 1'b0;

  task automatic cmp_chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_tests++;
    if (act !== exp) begin
      cmp_fail++;
      $display("FAIL model %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic lit_chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    lit_tests++;
    if (act !== exp) begin
      lit_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        cmp_chk("e_valE",  e_valE,       mc.val_e);
        cmp_chk("e_Cnd",   e_Cnd,        mc.cnd);
        cmp_chk("e_dstE",  e_dstE,       mc.dst_e);
        cmp_chk("cc",      cc,           x_cc);
        cmp_chk("M_stat",  eif.M_stat,   x_stat);
        cmp_chk("M_icode", eif.M_icode,  x_icode);
        cmp_chk("M_Cnd",   eif.M_Cnd,    x_cnd);
        cmp_chk("M_valE",  eif.M_valE,   x_vale);
        cmp_chk("M_valA",  eif.M_valA,   x_vala);
        cmp_chk("M_destE", eif.M_destE,  x_deste);
        cmp_chk("M_destM", eif.M_destM,  x_destm);
      end
    end
  end

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                       input logic [63:0] vb, input logic [63:0] vc,
                       input logic [3:0] de, input logic [3:0] dm);
    eif.E_icode = ic;
    eif.E_ifun  = fn;
    eif.E_valA  = va;
    eif.E_valB  = vb;
    eif.E_valC  = vc;
    eif.E_dstE  = de;
    eif.E_dstM  = dm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jxx_sweep();
    for (int f = 0; f < 8; f++) begin
      drive(JXX, 4'(f), 64'h0, 64'h0, 64'h40 + 64'(f), 4'hF, 4'hF);
      tick();
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    m_stat   = STAT_AOK;
    W_stat   = STAT_AOK;
    M_bubble = 1'b0;
    eif.E_stat = STAT_AOK;
    drive(NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    lit_chk("reset M_icode", eif.M_icode, 64'h1);
    lit_chk("reset M_stat",  eif.M_stat,  64'b1000);
    lit_chk("reset M_destE", eif.M_destE, 64'hF);
    lit_chk("reset cc",      cc,          64'b100);
    tick();

    drive(OPQ, ALU_SUB, 64'd5, 64'd3, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("sub M_valE", eif.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    lit_chk("sub cc",     cc,         64'b010);
    drive(JXX, C_L, 64'h0, 64'h0, 64'h80, 4'hF, 4'hF);
    #1;
    lit_chk("jl e_Cnd", e_Cnd, 64'h1);
    tick();
    jxx_sweep();

    drive(OPQ, ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h1, 4'hF);
    tick();
    lit_chk("add ovf M_valE", eif.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    lit_chk("add ovf cc",     cc,         64'b011);
    m_stat = STAT_ADR;
    drive(OPQ, ALU_ADD, 64'h0, 64'h0, 64'h0, 4'h1, 4'hF);
    tick();
    lit_chk("m_stat ADR cc held", cc,         64'b011);
    lit_chk("m_stat ADR M_valE",  eif.M_valE, 64'h0);
    m_stat = STAT_AOK;
    jxx_sweep();

    drive(OPQ, ALU_XOR, 64'h55, 64'h55, 64'h0, 4'h4, 4'hF);
    tick();
    lit_chk("xor cc", cc, 64'b100);
    drive(RRMOVQ, C_NE, 64'h1234, 64'h9999, 64'h0, 4'h3, 4'hF);
    #1;
    lit_chk("cmovne ZF=1 e_Cnd",  e_Cnd,  64'h0);
    lit_chk("cmovne ZF=1 e_dstE", e_dstE, 64'hF);
    tick();
    lit_chk("cmovne ZF=1 M_destE", eif.M_destE, 64'hF);
    lit_chk("cmovne M_valE",       eif.M_valE,  64'h1234);
    drive(OPQ, ALU_ADD, 64'd1, 64'd1, 64'h0, 4'h5, 4'hF);
    tick();
    lit_chk("add 1+1 cc", cc, 64'b000);
    drive(RRMOVQ, C_NE, 64'h1234, 64'h9999, 64'h0, 4'h3, 4'hF);
    tick();
    lit_chk("cmovne ZF=0 M_destE", eif.M_destE, 64'h3);
    lit_chk("cmovne ZF=0 M_Cnd",   eif.M_Cnd,   64'h1);
    jxx_sweep();

    drive(PUSHQ, 4'h0, 64'hABC, 64'h100, 64'h0, 4'h4, 4'hF);
    tick();
    lit_chk("pushq M_valE", eif.M_valE, 64'hF8);
    lit_chk("pushq M_valA", eif.M_valA, 64'hABC);
    drive(POPQ, 4'h0, 64'hDEF, 64'hF8, 64'h0, 4'h4, 4'h6);
    tick();
    lit_chk("popq M_valE",  eif.M_valE,  64'h100);
    lit_chk("popq M_destM", eif.M_destM, 64'h6);
    drive(MRMOVQ, 4'h0, 64'h0, 64'h20, 64'h10, 4'hF, 4'h7);
    tick();
    lit_chk("mrmovq M_valE", eif.M_valE, 64'h30);
    drive(IRMOVQ, 4'h0, 64'h0, 64'h77, 64'h42, 4'h2, 4'hF);
    tick();
    drive(CALL, 4'h0, 64'h0, 64'h200, 64'h300, 4'h4, 4'hF);
    tick();
    drive(RET, 4'h0, 64'h0, 64'h1F8, 64'h0, 4'h4, 4'hF);
    tick();
    drive(RMMOVQ, 4'h0, 64'h5, 64'h100, 64'hFFFF_FFFF_FFFF_FFF0, 4'hF, 4'hF);
    tick();

    M_bubble = 1'b1;
    drive(OPQ, ALU_ADD, 64'h0, 64'h0, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("bubble M_icode", eif.M_icode, 64'h1);
    lit_chk("bubble M_stat",  eif.M_stat,  64'b1000);
    lit_chk("bubble M_destE", eif.M_destE, 64'hF);
    lit_chk("bubble cc held", cc,          64'b000);
    M_bubble = 1'b0;

    eif.E_stat = STAT_HLT;
    drive(OPQ, ALU_ADD, 64'h0, 64'h0, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("halt cc held", cc,         64'b000);
    lit_chk("halt M_stat",  eif.M_stat, 64'b0100);
    drive(OPQ, 4'h7, 64'h5, 64'h5, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("halt bad ifun M_stat", eif.M_stat, 64'b0100);
    eif.E_stat = STAT_AOK;
    drive(OPQ, 4'h7, 64'h5, 64'h5, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("bad ifun M_stat", eif.M_stat, 64'b0001);
    lit_chk("bad ifun M_valE", eif.M_valE, 64'h0);
    W_stat = STAT_ADR;
    drive(OPQ, ALU_SUB, 64'd1, 64'd0, 64'h0, 4'h2, 4'hF);
    tick();
    W_stat = STAT_AOK;
    drive(OPQ, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("sub ovf cc", cc, 64'b011);
    drive(OPQ, ALU_AND, 64'hF0F0, 64'hFF00, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("and M_valE", eif.M_valE, 64'hF000);
    jxx_sweep();

    drive(OPQ, ALU_ADD, 64'd3, 64'd4, 64'h0, 4'h2, 4'hF);
    tick();
    lit_chk("pre-reset M_valE",  eif.M_valE,  64'h7);
    lit_chk("pre-reset M_icode", eif.M_icode, 64'h6);
    #2;
    rst_n = 1'b0;
    #1;
    lit_chk("async rst M_icode", eif.M_icode, 64'h1);
    lit_chk("async rst M_valE",  eif.M_valE,  64'h0);
    lit_chk("async rst M_destE", eif.M_destE, 64'hF);
    lit_chk("async rst cc",      cc,          64'b100);
    rst_n = 1'b1;
    drive(NOP, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", cmp_tests + lit_tests, cmp_fail + lit_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y-86 pipeline execute stage; sits directly upstream of data_memory.
- Consumes the E pipeline register fields and computes the ALU result, the branch/cmov condition and the condition codes.
- Drives the M pipeline register (M_stat, M_icode, M_Cnd, M_valE, M_valA, M_destE, M_destM) that data_memory reads.
- Exposes e_valE and e_dstE combinationally for forwarding into decode.

Parameters:
- DATA_W, 64, datapath width of valA/valB/valC/valE.
- REG_NONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- E_stat  in  4 ([0:3])  one-hot stat {AOK,HLT,ADR,INS}: AOK=4'b1000, HLT=4'b0100, ADR=4'b0010, INS=4'b0001.
- E_icode  in  4  instruction code.
- E_ifun  in  4  function code.
- E_valC  in  DATA_W  constant word.
- E_valA  in  DATA_W  operand A.
- E_valB  in  DATA_W  operand B.
- E_dstE  in  4  ALU destination register.
- E_dstM  in  4  memory destination register.
- m_stat  in  4  stat currently computed by the memory stage.
- W_stat  in  4  stat held in the W register.
- M_bubble  in  1  from pipeline control: load a bubble into M.
- e_valE  out  DATA_W  combinational ALU result.
- e_Cnd  out  1  combinational condition result.
- e_dstE  out  4  combinational effective dstE, used for forwarding.
- M_stat  out  4  registered.
- M_icode  out  4  registered.
- M_Cnd  out  1  registered.
- M_valE  out  DATA_W  registered.
- M_valA  out  DATA_W  registered.
- M_destE  out  4  registered.
- M_destM  out  4  registered.
- cc  out  3  registered {ZF,SF,OF}.

Behaviour:
- Reset: rst_n low asynchronously forces the M register to a bubble: M_icode=4'h1 (nop), M_stat=4'b1000, M_Cnd=0, M_valE=0, M_valA=0, M_destE=M_destM=REG_NONE. cc resets to {1,0,0}. Reset asserted mid-instruction discards that instruction with no partial update.
- aluA selection:
  - rrmovq(2), OPq(6): E_valA.
  - irmovq(3), rmmovq(4), mrmovq(5): E_valC.
  - call(8), pushq(A): -8.
  - ret(9), popq(B): +8.
  - all other icodes: 0.
- aluB selection: E_valB for icodes 4, 5, 6, 8, 9, A, B; 0 for icodes 2, 3 and all others.
- ALU function, applied only when icode=6 (other icodes always add):
  - ifun 0: add, aluB+aluA.
  - ifun 1: sub, aluB-aluA.
  - ifun 2: and.
  - ifun 3: xor.
  - ifun >3 with icode=6: result 0, and the instruction's M_stat is forced to INS unless E_stat is already non-AOK.
- Arithmetic is modulo 2^DATA_W; no carry output.
- Flags:
  - ZF = (result==0); SF = result[MSB].
  - OF for add: the operands have the same sign and the result sign differs from it.
  - OF for sub: sign(aluA)!=sign(aluB) and sign(result)!=sign(aluB).
  - OF for and/xor: 0.
- CC update: cc loads at posedge only when icode=6, E_stat=AOK, m_stat=AOK, W_stat=AOK, and M_bubble=0. Otherwise cc holds.
- Condition, for icode 2 or 7, evaluated on the current cc (not the same-cycle update):
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun >6: 0.
  - e_Cnd=0 for all other icodes.
- e_dstE = REG_NONE when icode=2 and e_Cnd=0; otherwise E_dstE.
- M register: at posedge with M_bubble=0, loads M_stat (E_stat or the INS override), E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM. Latency is one cycle from E to M.
- M_bubble=1 at posedge loads the reset/bubble values. It takes priority over all other updates, including the cc update.
- A halted or faulted instruction in E (E_stat non-AOK) still passes to M unchanged; only its cc update is suppressed.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - ALU ifun constants.
  - Condition ifun constants.
  - Stat one-hot constants.
  - REG_NONE.
- One sub-module y86_alu: combinational aluA/aluB/ifun in, result and {ZF,SF,OF} out.
- Condition evaluation, the cc register and the M register stay in execute_stage.

Test Plan:
- Reset, then release: M_icode=1, M_stat=4'b1000, M_destE=F, cc=3'b100.
- OPq sub, valA=5, valB=3, all stat AOK: next cycle M_valE=0xFFFF_FFFF_FFFF_FFFE and cc={0,1,0}. Then jXX ifun 2 (l) gives e_Cnd=1.
- OPq add, valA=valB=0x7FFF_FFFF_FFFF_FFFF: M_valE=0xFFFF_FFFF_FFFF_FFFE and cc={0,1,1}. Repeat with m_stat=4'b0010: cc unchanged.
- cmovne with ZF=1, E_dstE=3: e_Cnd=0, e_dstE=F, M_destE=F. With ZF=0: M_destE=3.
- pushq valB=0x100: M_valE=0xF8, M_valA=E_valA. popq valB=0xF8: M_valE=0x100.
- M_bubble=1 together with OPq ifun 0: M holds nop/AOK and cc is unchanged. rst_n pulsed low mid-cycle: M returns to the bubble values immediately, without waiting for a clock edge.
